datapath_ctrl: RTL and testbench

- Control-unit FSM for the 8-bit general datapath: sequences fetch, decode and execute for the 3-bit-opcode instruction set.
- Drives every datapath control line: PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel.
- Consumes datapath status: Aeq0, Apos, IR opcode.
- Adds an Enter-key handshake for the IN instruction and a Halt indication; sits beside the datapath in the processor top level.

---
 rtl/datapath_pkg.sv | 33 +++
 rtl/enter_sync.sv | 21 ++
 rtl/datapath_ctrl.sv | 131 +++++++++++++
 tb/tb_datapath_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared encodings for the 8-bit datapath control unit.
// Covers opcodes, A-mux selects and FSM state codes.
package datapath_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  typedef enum logic [3:0] {
    StStart  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoad   = 4'd3,
    StStore  = 4'd4,
    StAdd    = 4'd5,
    StSub    = 4'd6,
    StInWait = 4'd7,
    StInRel  = 4'd8,
    StJz     = 4'd9,
    StJpos   = 4'd10,
    StHalt   = 4'd11
  } state_e;

endpackage

// File: rtl/enter_sync.sv
// Two-flop synchronizer for the asynchronous Enter key.
module enter_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/datapath_ctrl.sv
// Fetch/decode/execute control FSM for the 8-bit datapath, with an Enter-key
// handshake for IN and a sticky Halt state.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int unsigned SYNC_ENTER = 1,
  parameter int unsigned OP_W       = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [OP_W-1:0] IR,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            Enter,
  output logic            PCload,
  output logic            JMPmux,
  output logic            IRload,
  output logic            Meminst,
  output logic            MemWr,
  output logic            Aload,
  output logic            Sub,
  output logic [1:0]      Asel,
  output logic            Halt,
  output logic [3:0]      State
);

  state_e state_q, state_d;
  logic   enter_s;

  if (SYNC_ENTER == 1) begin : g_sync
    enter_sync u_enter_sync (
      .clk_i  (Clock),
      .rst_ni (Reset),
      .d_i    (Enter),
      .q_o    (enter_s)
    );
  end else begin : g_nosync
    assign enter_s = Enter;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are Moore except PCload in the jump states and Aload in IN_WAIT.
  always_comb begin
    state_d = state_q;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    IRload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ALU;
    Halt    = 1'b0;
    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        Meminst = 1'b1;
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        case (IR)
          OP_LOAD:  state_d = StLoad;
          OP_STORE: state_d = StStore;
          OP_ADD:   state_d = StAdd;
          OP_SUB:   state_d = StSub;
          OP_IN:    state_d = StInWait;
          OP_JZ:    state_d = StJz;
          OP_JPOS:  state_d = StJpos;
          OP_HALT:  state_d = StHalt;
          default:  state_d = StStart;
        endcase
      end
      StLoad: begin
        Asel    = ASEL_MEM;
        Aload   = 1'b1;
        state_d = StFetch;
      end
      StStore: begin
        MemWr   = 1'b1;
        state_d = StFetch;
      end
      StAdd: begin
        Aload   = 1'b1;
        state_d = StFetch;
      end
      StSub: begin
        Sub     = 1'b1;
        Aload   = 1'b1;
        state_d = StFetch;
      end
      StInWait: begin
        Asel = ASEL_IN;
        if (enter_s) begin
          Aload   = 1'b1;
          state_d = StInRel;
        end
      end
      // Hold here until the key is released so one press loads A only once.
      StInRel: begin
        if (!enter_s) state_d = StFetch;
      end
      StJz: begin
        JMPmux  = 1'b1;
        PCload  = Aeq0;
        state_d = StFetch;
      end
      StJpos: begin
        JMPmux  = 1'b1;
        PCload  = Apos;
        state_d = StFetch;
      end
      StHalt: begin
        Halt    = 1'b1;
        state_d = StHalt;
      end
      default: state_d = StStart;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Randomized self-checking bench for datapath_ctrl: each instruction is
// checked cycle by cycle against the expected fetch/decode/execute sequence.
module tb_datapath_ctrl;
  import datapath_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] IR    = 3'b000;
  logic       Aeq0  = 1'b0;
  logic       Apos  = 1'b0;
  logic       Enter = 1'b0;
  logic       PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] State;

  int unsigned total = 0;
  int unsigned bad   = 0;

  datapath_ctrl #(
    .SYNC_ENTER (1),
    .OP_W       (3)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .Enter   (Enter),
    .PCload  (PCload),
    .JMPmux  (JMPmux),
    .IRload  (IRload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .Halt    (Halt),
    .State   (State)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packed view: {PCload,JMPmux,IRload,Meminst,MemWr,Aload,Sub,Asel,Halt}
  function automatic logic [9:0] vec(input bit pc, input bit jm, input bit ir, input bit mi,
                                     input bit mw, input bit al, input bit sb,
                                     input logic [1:0] as, input bit h);
    return {pc, jm, ir, mi, mw, al, sb, as, h};
  endfunction

  task automatic chk(input string tag, input logic [9:0] ev, input state_e es);
    logic [9:0] obs;
    obs = {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub, Asel, Halt};
    check_eq({tag, "_out"}, 16'(obs), 16'(ev));
    check_eq({tag, "_st"}, 16'(State), 16'(es));
  endtask

  // Advance one clock; status inputs are re-randomized so Moore states must ignore them.
  task automatic step();
    @(posedge Clock);
    #1;
    Aeq0 = 1'($urandom);
    Apos = 1'($urandom);
    #1;
  endtask

  // Enter schedule relative to the first IN_WAIT cycle: low w cycles, high h cycles.
  function automatic bit sched(input int c, input int w, input int h);
    return (c >= w) && (c < w + h);
  endfunction

  task automatic run_in(input int w, input int h);
    bit in_rel = 1'b0;
    bit done   = 1'b0;
    bit es;
    int pulses = 0;
    int pulse_c = -1;
    int c;
    for (c = 0; c < w + h + 12; c++) begin
      Enter = sched(c, w, h);
      es = (c >= 2) ? sched(c - 2, w, h) : 1'b0;
      if (!in_rel) begin
        chk("in_wait", vec(0, 0, 0, 0, 0, es, 0, ASEL_IN, 0), StInWait);
        if (es) begin
          pulses++;
          pulse_c = c;
          in_rel = 1'b1;
        end
      end else begin
        chk("in_rel", vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StInRel);
        if (Aload) pulses++;
        if (!es) begin
          done = 1'b1;
          break;
        end
      end
      IR = 3'($urandom);
      step();
    end
    Enter = 1'b0;
    check_eq("in_done", 16'(done), 16'd1);
    check_eq("in_pulses", 16'(pulses), 16'd1);
    check_eq("in_lat", 16'(pulse_c), 16'(w + 2));
    check_eq("in_resume", 16'(c + 1), 16'(w + h + 3));
  endtask

  // Entered in FETCH; returns in the following FETCH (except HALT).
  task automatic run_instr(input logic [2:0] op, input int w, input int h);
    IR = op;
    chk("fetch", vec(1, 0, 1, 1, 0, 0, 0, ASEL_ALU, 0), StFetch);
    step();
    chk("decode", vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StDecode);
    step();
    IR = 3'($urandom);
    case (op)
      OP_LOAD:  chk("load", vec(0, 0, 0, 0, 0, 1, 0, ASEL_MEM, 0), StLoad);
      OP_STORE: chk("store", vec(0, 0, 0, 0, 1, 0, 0, ASEL_ALU, 0), StStore);
      OP_ADD:   chk("add", vec(0, 0, 0, 0, 0, 1, 0, ASEL_ALU, 0), StAdd);
      OP_SUB:   chk("sub", vec(0, 0, 0, 0, 0, 1, 1, ASEL_ALU, 0), StSub);
      OP_JZ:    chk("jz", vec(Aeq0, 1, 0, 0, 0, 0, 0, ASEL_ALU, 0), StJz);
      OP_JPOS:  chk("jpos", vec(Apos, 1, 0, 0, 0, 0, 0, ASEL_ALU, 0), StJpos);
      OP_IN:    run_in(w, h);
      default: begin
        for (int i = 0; i < 25; i++) begin
          Enter = 1'($urandom);
          chk("halt", vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 1), StHalt);
          IR = 3'($urandom);
          step();
        end
        Enter = 1'b0;
        return;
      end
    endcase
    step();
  endtask

  // Reset pulse from the current cycle; leaves the DUT in FETCH.
  task automatic reset_pulse(input string tag);
    Reset = 1'b0;
    #1;
    chk({tag, "_rst"}, vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StStart);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk({tag, "_rel"}, vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StStart);
    step();
  endtask

  initial begin
    #1;
    chk("por", vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StStart);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("start", vec(0, 0, 0, 0, 0, 0, 0, ASEL_ALU, 0), StStart);
    step();

    // Reset asserted while in FETCH.
    chk("fetch0", vec(1, 0, 1, 1, 0, 0, 0, ASEL_ALU, 0), StFetch);
    reset_pulse("mid_fetch");

    run_instr(OP_LOAD, 0, 1);
    run_instr(OP_SUB, 0, 1);
    run_instr(OP_STORE, 0, 1);
    run_instr(OP_IN, 10, 5);
    run_instr(OP_JZ, 0, 1);
    run_instr(OP_JPOS, 0, 1);

    // Reset in an execute cycle must suppress the MemWr/Aload pulse.
    IR = OP_STORE;
    step();
    step();
    reset_pulse("abort_store");
    IR = OP_LOAD;
    step();
    step();
    reset_pulse("abort_load");

    for (int n = 0; n < 150; n++) begin
      run_instr(3'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                int'($urandom_range(1, 5)));
    end

    run_instr(OP_HALT, 0, 1);
    reset_pulse("halt");
    run_instr(OP_ADD, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
